// File: rtl/nbuf_sm_if.sv
// nbuf_sm_if: port bundle between the N-buffer ownership controller and the
// three client stages (write, access, read) that take turns on a ring of RAM
// buffers.
//
// Handshake: each stage has an *_ok / *_ptr grant from the controller and a
// *_done release from the client. *_ok high means the stage owns buffer *_ptr
// and *_ptr is stable. The client releases the buffer by pulsing *_done for
// exactly one cycle while *_ok is high. A *_done while *_ok is low is a
// protocol error: it is ignored apart from setting the sticky err flag.
// access_skip_read is only meaningful in the cycle access_done is high.
//
// Signals:
//   write_ok/write_ptr, write_done                    write stage
//   access_ok/access_ptr, access_done,
//   access_skip_read                                  in-place access stage
//   read_ok/read_ptr, read_done                       read stage
//   free_cnt       number of buffers currently writable
//   err            sticky protocol error
//   dbg_buf_state  per-buffer ownership state, 2 bits per buffer
//                  (0 writable, 1 accessible, 2 readable)
//
// Modports: master = the controller, slave = the client stages.

interface nbuf_sm_if #(
  parameter int NBUF_LOG2 = 1
);
  logic                           write_ok;
  logic [NBUF_LOG2-1:0]           write_ptr;
  logic                           write_done;

  logic                           access_ok;
  logic [NBUF_LOG2-1:0]           access_ptr;
  logic                           access_done;
  logic                           access_skip_read;

  logic                           read_ok;
  logic [NBUF_LOG2-1:0]           read_ptr;
  logic                           read_done;

  logic [NBUF_LOG2:0]             free_cnt;
  logic                           err;
  logic [2*(1<<NBUF_LOG2)-1:0]    dbg_buf_state;

  modport master (
    output write_ok, write_ptr,
    input  write_done,
    output access_ok, access_ptr,
    input  access_done, access_skip_read,
    output read_ok, read_ptr,
    input  read_done,
    output free_cnt, err, dbg_buf_state
  );

  modport slave (
    input  write_ok, write_ptr,
    output write_done,
    input  access_ok, access_ptr,
    output access_done, access_skip_read,
    input  read_ok, read_ptr,
    output read_done,
    input  free_cnt, err, dbg_buf_state
  );
endinterface

// File: rtl/nbuf_sm.sv
// nbuf_sm: ownership controller for a ring of 2^NBUF_LOG2 packet buffers.
// Buffers are handed, strictly in ring order, from the write stage to an
// optional in-place access stage and then to the read stage, after which
// they become writable again. The access stage may also discard a buffer,
// sending it straight back to writable.
//
// Parameters:
//   NBUF_LOG2    log2 of the buffer count (1..4)
//   SKIP_ACCESS  1 removes the access stage; written buffers become readable
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   clear  synchronous active-high clear, identical in effect to reset
//   bus    nbuf_sm_if master modport (grants, releases, free_cnt, err)
//
// Every output is a register or a decode of registers; the done inputs only
// influence next-state logic.

module nbuf_sm #(
  parameter int NBUF_LOG2   = 1,
  parameter bit SKIP_ACCESS = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clear,
  nbuf_sm_if.master bus
);

  localparam int NBUF = 1 << NBUF_LOG2;
  localparam int CW   = NBUF_LOG2 + 1;
  localparam logic [NBUF_LOG2-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    BUF_WRITABLE   = 2'd0,
    BUF_ACCESSIBLE = 2'd1,
    BUF_READABLE   = 2'd2
  } buf_state_e;

  typedef enum logic {
    PORT_WAIT = 1'b0,
    PORT_USE  = 1'b1
  } port_state_e;

  buf_state_e           buf_q [NBUF];
  buf_state_e           buf_d [NBUF];

  port_state_e          wr_q, wr_d;
  port_state_e          ac_q, ac_d;
  port_state_e          rd_q, rd_d;

  logic [NBUF_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [NBUF_LOG2-1:0] ac_ptr_q, ac_ptr_d;
  logic [NBUF_LOG2-1:0] rd_ptr_q, rd_ptr_d;

  logic [CW-1:0]        free_q, free_d;
  logic                 err_q, err_d;

  // Buffers entering / leaving WRITABLE this cycle. At most two can enter
  // (an access discard and a read release) and only the write stage leaves.
  logic [1:0]           enter_cnt;
  logic                 leave_cnt;

  logic                 wr_stray, ac_stray, rd_stray;

  // A release pulse while the stage does not own a buffer is a protocol
  // error. The access stage does not exist when SKIP_ACCESS is set, so its
  // inputs can never be in error then.
  assign wr_stray = bus.write_done && (wr_q != PORT_USE);
  assign ac_stray = !SKIP_ACCESS && bus.access_done && (ac_q != PORT_USE);
  assign rd_stray = bus.read_done && (rd_q != PORT_USE);

  // Registers
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < NBUF; i++) begin
        buf_q[i] <= BUF_WRITABLE;
      end
      wr_q     <= PORT_WAIT;
      ac_q     <= PORT_WAIT;
      rd_q     <= PORT_WAIT;
      wr_ptr_q <= '0;
      ac_ptr_q <= '0;
      rd_ptr_q <= '0;
      free_q   <= CW'(NBUF);
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NBUF; i++) begin
        buf_q[i] <= buf_d[i];
      end
      wr_q     <= wr_d;
      ac_q     <= ac_d;
      rd_q     <= rd_d;
      wr_ptr_q <= wr_ptr_d;
      ac_ptr_q <= ac_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      free_q   <= free_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic for the buffer states and the three port FSMs.
  // A port in WAIT looks at the registered state of the buffer under its
  // pointer, so a buffer released at one edge is picked up by the next stage
  // one edge later. The three stages always point at distinct buffers while
  // they are in USE, so their updates to buf_d never collide.
  always_comb begin
    for (int i = 0; i < NBUF; i++) begin
      buf_d[i] = buf_q[i];
    end
    wr_d      = wr_q;
    ac_d      = ac_q;
    rd_d      = rd_q;
    wr_ptr_d  = wr_ptr_q;
    ac_ptr_d  = ac_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    enter_cnt = 2'd0;
    leave_cnt = 1'b0;
    err_d     = err_q | wr_stray | ac_stray | rd_stray;

    // Write stage
    case (wr_q)
      PORT_WAIT: begin
        if (buf_q[wr_ptr_q] == BUF_WRITABLE) begin
          wr_d = PORT_USE;
        end
      end
      PORT_USE: begin
        if (bus.write_done) begin
          buf_d[wr_ptr_q] = SKIP_ACCESS ? BUF_READABLE : BUF_ACCESSIBLE;
          wr_d            = PORT_WAIT;
          wr_ptr_d        = wr_ptr_q + PTR_ONE;
          leave_cnt       = 1'b1;
        end
      end
    endcase

    // Access stage; held idle at pointer 0 when bypassed.
    if (!SKIP_ACCESS) begin
      case (ac_q)
        PORT_WAIT: begin
          if (buf_q[ac_ptr_q] == BUF_ACCESSIBLE) begin
            ac_d = PORT_USE;
          end
        end
        PORT_USE: begin
          if (bus.access_done) begin
            if (bus.access_skip_read) begin
              buf_d[ac_ptr_q] = BUF_WRITABLE;
              enter_cnt       = enter_cnt + 2'd1;
            end else begin
              buf_d[ac_ptr_q] = BUF_READABLE;
            end
            ac_d     = PORT_WAIT;
            ac_ptr_d = ac_ptr_q + PTR_ONE;
          end
        end
      endcase
    end

    // Read stage
    case (rd_q)
      PORT_WAIT: begin
        if (buf_q[rd_ptr_q] == BUF_READABLE) begin
          rd_d = PORT_USE;
        end
      end
      PORT_USE: begin
        if (bus.read_done) begin
          buf_d[rd_ptr_q] = BUF_WRITABLE;
          rd_d            = PORT_WAIT;
          rd_ptr_d        = rd_ptr_q + PTR_ONE;
          enter_cnt       = enter_cnt + 2'd1;
        end
      end
    endcase

    // Net change of writable buffers; cannot leave 0..NBUF because every
    // increment and decrement corresponds to a real buffer transition.
    free_d = free_q + CW'(enter_cnt) - CW'(leave_cnt);
  end

  // Outputs
  assign bus.write_ok   = (wr_q == PORT_USE);
  assign bus.write_ptr  = wr_ptr_q;
  assign bus.access_ok  = (ac_q == PORT_USE);
  assign bus.access_ptr = ac_ptr_q;
  assign bus.read_ok    = (rd_q == PORT_USE);
  assign bus.read_ptr   = rd_ptr_q;
  assign bus.free_cnt   = free_q;
  assign bus.err        = err_q;

  always_comb begin
    bus.dbg_buf_state = '0;
    for (int i = 0; i < NBUF; i++) begin
      bus.dbg_buf_state[2*i +: 2] = buf_q[i];
    end
  end

endmodule

// File: tb/tb_nbuf_sm.sv
// tb_nbuf_sm: self-checking bench for nbuf_sm.
// Instance u_a: 4 buffers with the access stage; u_b: 2 buffers, bypassed.
// The reference for u_a tracks each buffer's owner, each stage's ring
// position and whether each stage currently holds a grant; free_cnt is
// derived by counting writable buffers.

module tb_nbuf_sm;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic clr_a = 1'b0;
  logic rst_b = 1'b0;
  logic clr_b = 1'b0;

  nbuf_sm_if #(.NBUF_LOG2(2)) ia ();
  nbuf_sm_if #(.NBUF_LOG2(1)) ib ();

  nbuf_sm #(.NBUF_LOG2(2), .SKIP_ACCESS(1'b0)) u_a (
    .clk   (clk),
    .reset (rst_a),
    .clear (clr_a),
    .bus   (ia.master)
  );

  nbuf_sm #(.NBUF_LOG2(1), .SKIP_ACCESS(1'b1)) u_b (
    .clk   (clk),
    .reset (rst_b),
    .clear (clr_b),
    .bus   (ib.master)
  );

  int checks = 0;
  int errors = 0;

  // Reference model for u_a: buffer owners 0 writable, 1 accessible,
  // 2 readable; positions are counts taken modulo 4.
  int m_buf [4];
  int m_wp, m_ap, m_rp;
  bit m_wok, m_aok, m_rok, m_err;

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < 4; i++) if (m_buf[i] == 0) n++;
    return n;
  endfunction

  function automatic logic [12:0] model_vec();
    return {m_wok, 2'(m_wp), m_aok, 2'(m_ap), m_rok, 2'(m_rp),
            3'(model_free()), m_err};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {ia.write_ok, ia.write_ptr, ia.access_ok, ia.access_ptr,
            ia.read_ok, ia.read_ptr, ia.free_cnt, ia.err};
  endfunction

  // One clock edge of the reference: a stage holding a grant releases on
  // done and advances; a stage without a grant gains one if the buffer at
  // its position was already in its stage before this edge.
  task automatic model_edge(input bit rs, input bit wd, input bit ad,
                            input bit sk, input bit rd);
    int old [4];
    for (int i = 0; i < 4; i++) old[i] = m_buf[i];
    if (rs) begin
      for (int i = 0; i < 4; i++) m_buf[i] = 0;
      m_wp = 0; m_ap = 0; m_rp = 0;
      m_wok = 0; m_aok = 0; m_rok = 0; m_err = 0;
      return;
    end
    if (m_wok) begin
      if (wd) begin m_buf[m_wp] = 1; m_wp = (m_wp + 1) % 4; m_wok = 0; end
    end else begin
      if (wd) m_err = 1;
      m_wok = (old[m_wp] == 0);
    end
    if (m_aok) begin
      if (ad) begin m_buf[m_ap] = sk ? 0 : 2; m_ap = (m_ap + 1) % 4; m_aok = 0; end
    end else begin
      if (ad) m_err = 1;
      m_aok = (old[m_ap] == 1);
    end
    if (m_rok) begin
      if (rd) begin m_buf[m_rp] = 0; m_rp = (m_rp + 1) % 4; m_rok = 0; end
    end else begin
      if (rd) m_err = 1;
      m_rok = (old[m_rp] == 2);
    end
  endtask

  // Driver: present inputs for one edge, advance the model, then drop all
  // pulses 1 time unit after the edge (outputs are settled from there on).
  task automatic tick(input bit wd, input bit ad, input bit sk,
                      input bit rd, input bit rs, input bit cl);
    ia.write_done = wd; ia.access_done = ad; ia.access_skip_read = sk;
    ia.read_done = rd; rst_a = rs; clr_a = cl;
    @(posedge clk);
    model_edge(rs | cl, wd, ad, sk, rd);
    #1;
    ia.write_done = 1'b0; ia.access_done = 1'b0; ia.access_skip_read = 1'b0;
    ia.read_done = 1'b0; rst_a = 1'b0; clr_a = 1'b0;
    ib.write_done = 1'b0; ib.access_done = 1'b0; ib.access_skip_read = 1'b0;
    ib.read_done = 1'b0; rst_b = 1'b0; clr_b = 1'b0;
  endtask

  // Idle until the model grants port 0 write, 1 access, 2 read, 3 all.
  task automatic wait_model(input int port, output bit to);
    int n = 0;
    to = 1'b0;
    while (!((port == 0 && m_wok) || (port == 1 && m_aok) ||
             (port == 2 && m_rok) || (port == 3 && m_wok && m_aok && m_rok))) begin
      if (n == 12) begin to = 1'b1; return; end
      tick(0, 0, 0, 0, 0, 0);
      n++;
    end
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 1, 0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_vec got %h exp %h", dut_vec(), model_vec());
    end
    checks++;
    if (ia.free_cnt !== 3'd4 || ia.write_ok !== 1'b0 || ia.err !== 1'b0) begin
      errors++; $display("FAIL reset_vals free=%0d wok=%b err=%b exp 4 0 0",
                         ia.free_cnt, ia.write_ok, ia.err);
    end
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (ia.write_ok !== 1'b1 || ia.write_ptr !== 2'd0) begin
      errors++; $display("FAIL first_write_ok got %b/%0d exp 1/0", ia.write_ok, ia.write_ptr);
    end
  endtask

  task automatic test_fill_drain();
    bit to;
    tick(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      wait_model(0, to);
      checks++;
      if (to || ia.write_ok !== 1'b1 || ia.write_ptr !== 2'(i)) begin
        errors++; $display("FAIL write_seq[%0d] got %b/%0d exp 1/%0d to=%b",
                           i, ia.write_ok, ia.write_ptr, i, to);
      end
      tick(1, 0, 0, 0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL write_vec[%0d] got %h exp %h", i, dut_vec(), model_vec());
      end
    end
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (ia.write_ok !== 1'b0 || ia.free_cnt !== 3'd0) begin
      errors++; $display("FAIL full got wok=%b free=%0d exp 0 0", ia.write_ok, ia.free_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      wait_model(1, to);
      checks++;
      if (to || ia.access_ptr !== 2'(i)) begin
        errors++; $display("FAIL access_seq[%0d] got %0d exp %0d to=%b", i, ia.access_ptr, i, to);
      end
      tick(0, 1, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      wait_model(2, to);
      checks++;
      if (to || ia.read_ok !== 1'b1 || ia.read_ptr !== 2'(i)) begin
        errors++; $display("FAIL read_seq[%0d] got %b/%0d exp 1/%0d to=%b",
                           i, ia.read_ok, ia.read_ptr, i, to);
      end
      tick(0, 0, 0, 1, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL read_vec[%0d] got %h exp %h", i, dut_vec(), model_vec());
      end
      if (i == 0) begin
        checks++;
        if (ia.write_ok !== 1'b0) begin
          errors++; $display("FAIL write_reopen_early got %b exp 0", ia.write_ok);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (ia.write_ok !== 1'b1 || ia.write_ptr !== 2'd0) begin
          errors++; $display("FAIL write_reopen got %b/%0d exp 1/0", ia.write_ok, ia.write_ptr);
        end
      end
    end
    repeat (2) tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (ia.read_ptr !== 2'd0 || ia.read_ok !== 1'b0 || ia.free_cnt !== 3'd4) begin
      errors++; $display("FAIL drained got rptr=%0d rok=%b free=%0d exp 0 0 4",
                         ia.read_ptr, ia.read_ok, ia.free_cnt);
    end
  endtask

  task automatic test_skip_read();
    bit to;
    tick(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      wait_model(0, to);
      tick(1, 0, 0, 0, 0, 0);
    end
    wait_model(1, to);
    tick(0, 1, 0, 0, 0, 0);          // buffer 0 kept for reading
    wait_model(1, to);
    checks++;
    if (to || ia.access_ptr !== 2'd1 || ia.free_cnt !== 3'd1) begin
      errors++; $display("FAIL skip_pre got aptr=%0d free=%0d exp 1 1 to=%b",
                         ia.access_ptr, ia.free_cnt, to);
    end
    tick(0, 1, 1, 0, 0, 0);          // buffer 1 discarded
    checks++;
    if (ia.free_cnt !== 3'd2) begin
      errors++; $display("FAIL skip_free got %0d exp 2", ia.free_cnt);
    end
    wait_model(1, to);
    tick(0, 1, 0, 0, 0, 0);          // buffer 2 kept
    wait_model(2, to);
    checks++;
    if (to || ia.read_ptr !== 2'd0) begin
      errors++; $display("FAIL skip_read0 got %0d exp 0 to=%b", ia.read_ptr, to);
    end
    tick(0, 0, 0, 1, 0, 0);
    repeat (4) tick(0, 0, 0, 0, 0, 0);
    // The read stage now sits on buffer 1, which went back to writable.
    checks++;
    if (ia.read_ok !== 1'b0 || ia.read_ptr !== 2'd1) begin
      errors++; $display("FAIL skip_not_readable got %b/%0d exp 0/1", ia.read_ok, ia.read_ptr);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL skip_vec got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_stray();
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    checks++;
    if (ia.err !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL stray_read got %h exp %h", dut_vec(), model_vec());
    end
    tick(0, 0, 0, 0, 0, 1);
    checks++;
    if (ia.err !== 1'b0 || ia.free_cnt !== 3'd4) begin
      errors++; $display("FAIL clear got err=%b free=%0d exp 0 4", ia.err, ia.free_cnt);
    end
  endtask

  task automatic test_reset_in_use();
    bit to;
    tick(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      wait_model(0, to);
      tick(1, 0, 0, 0, 0, 0);
    end
    wait_model(1, to);
    tick(0, 1, 0, 0, 0, 0);
    wait_model(3, to);
    checks++;
    if (to || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL all_use got %h exp %h to=%b", dut_vec(), model_vec(), to);
    end
    tick(1, 1, 0, 1, 1, 0);
    checks++;
    if (dut_vec() !== 13'd8) begin
      errors++; $display("FAIL reset_in_use got %h exp %h", dut_vec(), 13'd8);
    end
  endtask

  task automatic test_skip_access();
    rst_b = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (ib.write_ok !== 1'b1 || ib.write_ptr !== 1'b0 || ib.free_cnt !== 2'd2) begin
      errors++; $display("FAIL b_write got %b/%0d free=%0d exp 1/0 2",
                         ib.write_ok, ib.write_ptr, ib.free_cnt);
    end
    ib.write_done = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (ib.read_ok !== 1'b0 || ib.free_cnt !== 2'd1) begin
      errors++; $display("FAIL b_e0 got rok=%b free=%0d exp 0 1", ib.read_ok, ib.free_cnt);
    end
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (ib.read_ok !== 1'b1 || ib.read_ptr !== 1'b0 || ib.write_ptr !== 1'b1) begin
      errors++; $display("FAIL b_e1 got rok=%b rptr=%0d wptr=%0d exp 1 0 1",
                         ib.read_ok, ib.read_ptr, ib.write_ptr);
    end
    for (int i = 0; i < 3; i++) begin
      ib.access_done = 1'b1;
      ib.access_skip_read = 1'($urandom_range(0, 1));
      tick(0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (ib.err !== 1'b0 || ib.access_ok !== 1'b0 || ib.access_ptr !== 1'b0) begin
      errors++; $display("FAIL b_access got err=%b aok=%b aptr=%0d exp 0 0 0",
                         ib.err, ib.access_ok, ib.access_ptr);
    end
    ib.read_done = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (ib.free_cnt !== 2'd2 || ib.read_ptr !== 1'b1 || ib.read_ok !== 1'b0) begin
      errors++; $display("FAIL b_read got free=%0d rptr=%0d rok=%b exp 2 1 0",
                         ib.free_cnt, ib.read_ptr, ib.read_ok);
    end
    ib.read_done = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (ib.err !== 1'b1) begin
      errors++; $display("FAIL b_stray got %b exp 1", ib.err);
    end
  endtask

  task automatic test_random();
    bit wd, ad, sk, rd, rs;
    tick(0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 400; c++) begin
      wd = m_wok ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
      ad = m_aok ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
      rd = m_rok ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
      sk = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 149) == 0);
      tick(wd, ad, sk, rd, rs, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random[%0d] got %h exp %h", c, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    ia.write_done = 1'b0; ia.access_done = 1'b0; ia.access_skip_read = 1'b0;
    ia.read_done = 1'b0;
    ib.write_done = 1'b0; ib.access_done = 1'b0; ib.access_skip_read = 1'b0;
    ib.read_done = 1'b0;
    for (int i = 0; i < 4; i++) m_buf[i] = 0;
    m_wp = 0; m_ap = 0; m_rp = 0;
    m_wok = 0; m_aok = 0; m_rok = 0; m_err = 0;
    #2;
    test_reset();
    test_fill_drain();
    test_skip_read();
    test_stray();
    test_reset_in_use();
    test_skip_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
